// File: rtl/serdes_link.sv
// Loopback serial link for bring-up/BIST: incrementing-word frame generator, serializer and deserializer.
// Define SERDES_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module serdes_link #(
  parameter int              WIDTH = 10,
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             serdes_tx,
  input  logic             serdes_rx,
  output logic [WIDTH-1:0] data_out
);

`ifdef SERDES_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;

  tx_state_t        tx_state;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] tx_cnt;

  rx_state_t        rx_state;
  logic [WIDTH-1:0] shift;
  logic [CNT_W-1:0] rx_cnt;
  logic             par_ok;

  // TX: the state names the bit currently being driven on serdes_tx.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state  <= T_IDLE;
      serdes_tx <= 1'b1;
      word      <= SEED;
      tx_cnt    <= '0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (enable) begin
            tx_state  <= T_START;
            serdes_tx <= 1'b0;
          end
        end
        T_START: begin
          tx_state  <= T_DATA;
          serdes_tx <= word[0];
          tx_cnt    <= CNT_W'(1);
        end
        T_DATA: begin
          if (tx_cnt == CNT_W'(WIDTH)) begin
            if (PAR_EN) begin
              tx_state  <= T_PAR;
              serdes_tx <= ^word;
            end else begin
              tx_state  <= T_STOP;
              serdes_tx <= 1'b1;
            end
          end else begin
            serdes_tx <= word[tx_cnt];
            tx_cnt    <= tx_cnt + 1'b1;
          end
        end
        T_PAR: begin
          tx_state  <= T_STOP;
          serdes_tx <= 1'b1;
        end
        T_STOP: begin
          word <= word + STEP;
          if (enable) begin
            tx_state  <= T_START;
            serdes_tx <= 1'b0;
          end else begin
            tx_state  <= T_IDLE;
            serdes_tx <= 1'b1;
          end
        end
        default: begin
          tx_state  <= T_IDLE;
          serdes_tx <= 1'b1;
        end
      endcase
    end
  end

  // RX: data_out only ever loads a fully checked frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= R_IDLE;
      shift    <= '0;
      rx_cnt   <= '0;
      par_ok   <= 1'b1;
      data_out <= '0;
    end else begin
      case (rx_state)
        R_IDLE: begin
          if (!serdes_rx) begin
            rx_state <= R_DATA;
            rx_cnt   <= '0;
            par_ok   <= 1'b1;
          end
        end
        R_DATA: begin
          shift <= {serdes_rx, shift[WIDTH-1:1]};
          if (rx_cnt == CNT_W'(WIDTH - 1)) begin
            rx_state <= PAR_EN ? R_PAR : R_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        R_PAR: begin
          par_ok   <= (serdes_rx == ^shift);
          rx_state <= R_STOP;
        end
        R_STOP: begin
          if (serdes_rx) begin
            if (par_ok) data_out <= shift;
            rx_state <= R_IDLE;
          end else begin
            rx_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (serdes_rx) rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_link.sv
// Directed bench for serdes_link: reset/idle, loopback latency and wrap, enable drop,
// open-loop framing error recovery, mid-frame reset and (when enabled) parity checking.
module tb_serdes_link;
  localparam int WIDTH = 10;
`ifdef SERDES_PARITY_EN
  localparam int FL = WIDTH + 3;
`else
  localparam int FL = WIDTH + 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             serdes_tx;
  logic             serdes_rx;
  logic [WIDTH-1:0] data_out;
  logic             loop = 1'b1;
  logic             rx_drv = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  assign serdes_rx = loop ? serdes_tx : rx_drv;

  serdes_link #(.WIDTH(WIDTH), .SEED(10'h000), .STEP(10'h001)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .serdes_tx(serdes_tx),
    .serdes_rx(serdes_rx),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_drv = b;
    tick();
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < WIDTH; i++) drive_bit(w[i]);
`ifdef SERDES_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    loop = 1'b1;
    tick();
    tick();
    n_checks++;
    if (serdes_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tx: got %b want 1", serdes_tx);
    end
    n_checks++;
    if (data_out !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 000", data_out);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_checks++;
      if (serdes_tx !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_tx cycle %0d: got %b want 1", i, serdes_tx);
      end
    end
    n_checks++;
    if (data_out !== 10'h000) begin
      n_fail++;
      $display("FAIL idle_data: got %h want 000", data_out);
    end
  endtask

  // Runs 1026 frames so the payload walks through 0x3FF and wraps back to 0x000.
  task automatic test_loopback_wrap();
    logic [WIDTH-1:0] prev_w;
    logic [WIDTH-1:0] cur_w;
    enable = 1'b1;
    tick();
    n_checks++;
    if (serdes_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL start_bit: got %b want 0", serdes_tx);
    end
    for (int k = 1; k <= 1026; k++) begin
      prev_w = (k == 1) ? 10'h000 : WIDTH'(k - 2);
      cur_w  = WIDTH'(k - 1);
      repeat (FL - 1) tick();
      n_checks++;
      if (data_out !== prev_w) begin
        n_fail++;
        $display("FAIL loop_hold frame %0d: got %h want %h", k, data_out, prev_w);
      end
      tick();
      n_checks++;
      if (data_out !== cur_w) begin
        n_fail++;
        $display("FAIL loop_update frame %0d: got %h want %h", k, data_out, cur_w);
      end
    end
  endtask

  // Frame starting now carries word 1026 mod 1024 = 0x002.
  task automatic test_enable_drop();
    repeat (3) tick();
    enable = 1'b0;
    repeat (FL - 4) tick();
    n_checks++;
    if (data_out !== 10'h001) begin
      n_fail++;
      $display("FAIL drop_hold: got %h want 001", data_out);
    end
    tick();
    n_checks++;
    if (data_out !== 10'h002) begin
      n_fail++;
      $display("FAIL drop_complete: got %h want 002", data_out);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if (serdes_tx !== 1'b1 || data_out !== 10'h002) begin
        n_fail++;
        $display("FAIL drop_idle cycle %0d: got tx=%b data=%h want tx=1 data=002", i, serdes_tx, data_out);
      end
    end
  endtask

  task automatic test_framing_error();
    loop = 1'b0;
    rx_drv = 1'b1;
    tick();
    send_frame(10'h155, ^10'h155, 1'b0);
    n_checks++;
    if (data_out !== 10'h002) begin
      n_fail++;
      $display("FAIL frame_err_hold: got %h want 002", data_out);
    end
    drive_bit(1'b1);
    drive_bit(1'b1);
    n_checks++;
    if (data_out !== 10'h002) begin
      n_fail++;
      $display("FAIL frame_err_recover_hold: got %h want 002", data_out);
    end
    send_frame(10'h2AA, ^10'h2AA, 1'b1);
    n_checks++;
    if (data_out !== 10'h2AA) begin
      n_fail++;
      $display("FAIL good_frame: got %h want 2aa", data_out);
    end
`ifdef SERDES_PARITY_EN
    drive_bit(1'b1);
    send_frame(10'h003, 1'b1, 1'b1);
    n_checks++;
    if (data_out !== 10'h2AA) begin
      n_fail++;
      $display("FAIL parity_bad_hold: got %h want 2aa", data_out);
    end
    drive_bit(1'b1);
    send_frame(10'h003, 1'b0, 1'b1);
    n_checks++;
    if (data_out !== 10'h003) begin
      n_fail++;
      $display("FAIL parity_good: got %h want 003", data_out);
    end
`endif
    drive_bit(1'b1);
  endtask

  task automatic test_reset_mid_frame();
    logic [WIDTH-1:0] before_w;
    before_w = data_out;
    loop = 1'b1;
    enable = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (data_out !== before_w) begin
      n_fail++;
      $display("FAIL pre_reset_hold: got %h want %h", data_out, before_w);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (serdes_tx !== 1'b1 || data_out !== 10'h000) begin
      n_fail++;
      $display("FAIL mid_reset: got tx=%b data=%h want tx=1 data=000", serdes_tx, data_out);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (serdes_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_start: got %b want 0", serdes_tx);
    end
    repeat (2 * FL - 1) tick();
    n_checks++;
    if (data_out !== 10'h000) begin
      n_fail++;
      $display("FAIL restart_seed: got %h want 000", data_out);
    end
    tick();
    n_checks++;
    if (data_out !== 10'h001) begin
      n_fail++;
      $display("FAIL restart_second: got %h want 001", data_out);
    end
  endtask

  initial begin
    test_reset();
    test_loopback_wrap();
    test_enable_drop();
    test_framing_error();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
